match_ctl: RTL and testbench

MATCH_CTL -- requirements
Module: match_ctl

---
 rtl/match_pkg.sv | 24 ++
 rtl/match_ctl_frame_timer.sv | 38 +++
 rtl/match_ctl.sv | 147 ++++++++++++++
 tb/tb_match_ctl.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/match_pkg.sv
// Match controller shared types: FSM state encoding, winner codes, default timing constants.
// PAUSED only exists when MATCH_CTL_PAUSE_EN is defined.
package match_pkg;

    localparam int DEF_WIN_SCORE    = 7;
    localparam int DEF_SERVE_FRAMES = 30;
    localparam int DEF_PAUSE_FRAMES = 60;

    localparam logic [1:0] WIN_NONE = 2'd0;
    localparam logic [1:0] WIN_P1   = 2'd1;
    localparam logic [1:0] WIN_P2   = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SERVE  = 3'd1,
        ST_PLAY   = 3'd2,
        ST_GOAL   = 3'd3,
        ST_OVER   = 3'd4
`ifdef MATCH_CTL_PAUSE_EN
        , ST_PAUSED = 3'd5
`endif
    } state_t;

endpackage

// File: rtl/match_ctl_frame_timer.sv
// Frame tick counter with clear/enable; done_o is a combinational pulse on the tick reaching tc_i.
// A clear cycle swallows any coincident tick; counter wraps to zero on done.
module frame_timer #(
    parameter int W = 8
) (
    input  logic         clk_in,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic         tick_i,
    input  logic [W-1:0] tc_i,
    output logic         done_o
);

    localparam logic [W-1:0] ONE = W'(1);

    logic [W-1:0] cnt_q, cnt_d;

    assign done_o = en_i && tick_i && !clr_i && (cnt_q == tc_i - ONE);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i || done_o) begin
            cnt_d = '0;
        end else if (en_i && tick_i) begin
            cnt_d = cnt_q + ONE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/match_ctl.sv
// Pong match sequencer: serve delay, scoring, goal freeze and win detection; all outputs registered.
// Optional pause state compiled in with MATCH_CTL_PAUSE_EN.
module match_ctl
    import match_pkg::*;
#(
    parameter int WIN_SCORE    = DEF_WIN_SCORE,
    parameter int SERVE_FRAMES = DEF_SERVE_FRAMES,
    parameter int PAUSE_FRAMES = DEF_PAUSE_FRAMES
) (
    input  logic       clk_in,
    input  logic       rst_n,
    input  logic       frame_tick,
    input  logic       start_btn,
    input  logic       pause_btn,
    input  logic       goal_p1,
    input  logic       goal_p2,
    output logic       ball_run,
    output logic       ball_center,
    output logic       serve_dir,
    output logic [3:0] score_p1,
    output logic [3:0] score_p2,
    output logic [1:0] winner,
    output logic [2:0] state_o
);

    localparam logic [3:0] WIN4     = 4'(WIN_SCORE);
    localparam logic [7:0] SERVE_TC = 8'(SERVE_FRAMES);
    localparam logic [7:0] PAUSE_TC = 8'(PAUSE_FRAMES);

    state_t     state_q;
    logic [3:0] score_p1_q, score_p2_q;
    logic [1:0] winner_q;
    logic       serve_dir_q, ball_run_q, ball_center_q;
    logic       entry_q;
    logic       tmr_en, tmr_done;
    logic [7:0] tmr_tc;

`ifndef MATCH_CTL_PAUSE_EN
    logic unused_pause;
    assign unused_pause = pause_btn;
`endif

    assign tmr_en = (state_q == ST_SERVE) || (state_q == ST_GOAL);
    assign tmr_tc = (state_q == ST_GOAL) ? PAUSE_TC : SERVE_TC;

    // entry_q marks the first cycle of every state so the timer restarts from zero there
    frame_timer #(.W(8)) u_timer (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .clr_i  (entry_q),
        .en_i   (tmr_en),
        .tick_i (frame_tick),
        .tc_i   (tmr_tc),
        .done_o (tmr_done)
    );

    always_ff @(posedge clk_in) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            score_p1_q    <= 4'd0;
            score_p2_q    <= 4'd0;
            winner_q      <= WIN_NONE;
            serve_dir_q   <= 1'b0;
            ball_run_q    <= 1'b0;
            ball_center_q <= 1'b0;
            entry_q       <= 1'b0;
        end else begin
            ball_center_q <= 1'b0;
            entry_q       <= 1'b0;
            case (state_q)
                ST_IDLE, ST_OVER: begin
                    if (start_btn) begin
                        score_p1_q    <= 4'd0;
                        score_p2_q    <= 4'd0;
                        winner_q      <= WIN_NONE;
                        serve_dir_q   <= 1'b0;
                        ball_center_q <= 1'b1;
                        state_q       <= ST_SERVE;
                        entry_q       <= 1'b1;
                    end
                end
                ST_SERVE: begin
                    if (tmr_done) begin
                        ball_run_q <= 1'b1;
                        state_q    <= ST_PLAY;
                        entry_q    <= 1'b1;
                    end
                end
                ST_PLAY: begin
                    if (goal_p1) begin
                        if (score_p1_q < WIN4) score_p1_q <= score_p1_q + 4'd1;
                        serve_dir_q <= 1'b1;
                        ball_run_q  <= 1'b0;
                        state_q     <= ST_GOAL;
                        entry_q     <= 1'b1;
                    end else if (goal_p2) begin
                        if (score_p2_q < WIN4) score_p2_q <= score_p2_q + 4'd1;
                        serve_dir_q <= 1'b0;
                        ball_run_q  <= 1'b0;
                        state_q     <= ST_GOAL;
                        entry_q     <= 1'b1;
`ifdef MATCH_CTL_PAUSE_EN
                    end else if (pause_btn) begin
                        ball_run_q <= 1'b0;
                        state_q    <= ST_PAUSED;
                        entry_q    <= 1'b1;
`endif
                    end
                end
                ST_GOAL: begin
                    if (tmr_done) begin
                        entry_q <= 1'b1;
                        if (score_p1_q == WIN4) begin
                            winner_q <= WIN_P1;
                            state_q  <= ST_OVER;
                        end else if (score_p2_q == WIN4) begin
                            winner_q <= WIN_P2;
                            state_q  <= ST_OVER;
                        end else begin
                            ball_center_q <= 1'b1;
                            state_q       <= ST_SERVE;
                        end
                    end
                end
`ifdef MATCH_CTL_PAUSE_EN
                ST_PAUSED: begin
                    if (pause_btn) begin
                        ball_run_q <= 1'b1;
                        state_q    <= ST_PLAY;
                        entry_q    <= 1'b1;
                    end
                end
`endif
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign ball_run    = ball_run_q;
    assign ball_center = ball_center_q;
    assign serve_dir   = serve_dir_q;
    assign score_p1    = score_p1_q;
    assign score_p2    = score_p2_q;
    assign winner      = winner_q;
    assign state_o     = state_q;

endmodule

// File: tb/tb_match_ctl.sv
// Directed bench for match_ctl with default parameters (win 7, serve 30, pause 60).
module tb_match_ctl;

    logic       clk_in = 1'b0;
    logic       rst_n, frame_tick, start_btn, pause_btn, goal_p1, goal_p2;
    logic       ball_run, ball_center, serve_dir;
    logic [3:0] score_p1, score_p2;
    logic [1:0] winner;
    logic [2:0] state_o;

    int total = 0;
    int bad   = 0;
    int bc_cnt = 0;
    int bc0;

    localparam logic [2:0] S_IDLE = 3'd0, S_SERVE = 3'd1, S_PLAY = 3'd2, S_GOAL = 3'd3, S_OVER = 3'd4;

    always #5 clk_in = ~clk_in;

    match_ctl dut (
        .clk_in      (clk_in),
        .rst_n       (rst_n),
        .frame_tick  (frame_tick),
        .start_btn   (start_btn),
        .pause_btn   (pause_btn),
        .goal_p1     (goal_p1),
        .goal_p2     (goal_p2),
        .ball_run    (ball_run),
        .ball_center (ball_center),
        .serve_dir   (serve_dir),
        .score_p1    (score_p1),
        .score_p2    (score_p2),
        .winner      (winner),
        .state_o     (state_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // one clock; outputs sampled 1ns after the edge
    task automatic cyc();
        @(posedge clk_in);
        #1;
        if (ball_center === 1'b1) bc_cnt++;
    endtask

    task automatic tick_n(input int n);
        for (int i = 0; i < n; i++) begin
            frame_tick = 1'b1;
            cyc();
            frame_tick = 1'b0;
            cyc();
        end
    endtask

    initial begin
        rst_n = 1'b0; frame_tick = 1'b0; start_btn = 1'b0;
        pause_btn = 1'b0; goal_p1 = 1'b0; goal_p2 = 1'b0;
        repeat (3) cyc();
        chk("rst_state", state_o, S_IDLE);
        chk("rst_score1", score_p1, 0);
        chk("rst_score2", score_p2, 0);
        chk("rst_winner", winner, 0);
        chk("rst_run", ball_run, 0);
        chk("rst_center", ball_center, 0);
        chk("rst_dir", serve_dir, 0);
        rst_n = 1'b1;
        cyc();

        // start; a tick in the SERVE entry cycle must not count
        bc0 = bc_cnt;
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        chk("start_center", ball_center, 1);
        chk("start_state", state_o, S_SERVE);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        tick_n(29);
        chk("serve29_state", state_o, S_SERVE);
        chk("serve29_run", ball_run, 0);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("serve30_run", ball_run, 1);
        chk("serve30_state", state_o, S_PLAY);
        chk("serve_center_cnt", bc_cnt - bc0, 1);

        // player 2 goal
        goal_p2 = 1'b1;
        cyc();
        goal_p2 = 1'b0;
        chk("g2_score2", score_p2, 1);
        chk("g2_run", ball_run, 0);
        chk("g2_state", state_o, S_GOAL);
        cyc();
        bc0 = bc_cnt;
        tick_n(59);
        chk("g2_59_state", state_o, S_GOAL);
        chk("g2_59_center", bc_cnt - bc0, 0);
        frame_tick = 1'b1;
        cyc();
        frame_tick = 1'b0;
        chk("g2_center", ball_center, 1);
        chk("g2_dir", serve_dir, 0);
        chk("g2_reserve", state_o, S_SERVE);
        cyc();
        tick_n(30);
        chk("play2_state", state_o, S_PLAY);

        // simultaneous goals: player 1 wins priority
        goal_p1 = 1'b1; goal_p2 = 1'b1;
        cyc();
        goal_p1 = 1'b0; goal_p2 = 1'b0;
        chk("both_score1", score_p1, 1);
        chk("both_score2", score_p2, 1);
        chk("both_dir", serve_dir, 1);
        goal_p2 = 1'b1;
        cyc();
        goal_p2 = 1'b0;
        chk("goal_in_goal_ignored", score_p2, 1);
        tick_n(60);
        chk("both_reserve", state_o, S_SERVE);
        chk("both_reserve_dir", serve_dir, 1);
        tick_n(30);

        // player 1 scores to 7
        for (int g = 0; g < 6; g++) begin
            goal_p1 = 1'b1;
            cyc();
            goal_p1 = 1'b0;
            cyc();
            tick_n(60);
            if (g < 5) tick_n(30);
        end
        chk("win_state", state_o, S_OVER);
        chk("win_winner", winner, 1);
        chk("win_score1", score_p1, 7);
        chk("win_score2", score_p2, 1);
        goal_p1 = 1'b1; goal_p2 = 1'b1; frame_tick = 1'b1;
        cyc();
        goal_p1 = 1'b0; goal_p2 = 1'b0; frame_tick = 1'b0;
        tick_n(70);
        chk("over_hold_state", state_o, S_OVER);
        chk("over_hold_score1", score_p1, 7);
        chk("over_hold_score2", score_p2, 1);
        chk("over_hold_run", ball_run, 0);
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        chk("restart_score1", score_p1, 0);
        chk("restart_score2", score_p2, 0);
        chk("restart_winner", winner, 0);
        chk("restart_state", state_o, S_SERVE);

        // reset during GOAL with a goal and tick pending
        cyc();
        tick_n(30);
        goal_p1 = 1'b1;
        cyc();
        goal_p1 = 1'b0;
        chk("pre_rst_state", state_o, S_GOAL);
        chk("pre_rst_dir", serve_dir, 1);
        rst_n = 1'b0; goal_p1 = 1'b1; frame_tick = 1'b1;
        cyc();
        rst_n = 1'b1; goal_p1 = 1'b0; frame_tick = 1'b0;
        chk("mid_rst_state", state_o, S_IDLE);
        chk("mid_rst_score1", score_p1, 0);
        chk("mid_rst_dir", serve_dir, 0);
        chk("mid_rst_run", ball_run, 0);
        chk("mid_rst_center", ball_center, 0);
        chk("mid_rst_winner", winner, 0);

        // pause behaviour
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        cyc();
        tick_n(30);
        pause_btn = 1'b1;
        cyc();
        pause_btn = 1'b0;
`ifdef MATCH_CTL_PAUSE_EN
        chk("pause_state", state_o, 3'd5);
        chk("pause_run", ball_run, 0);
        tick_n(100);
        goal_p1 = 1'b1;
        cyc();
        goal_p1 = 1'b0;
        chk("pause_goal_state", state_o, 3'd5);
        chk("pause_goal_score", score_p1, 0);
        pause_btn = 1'b1;
        cyc();
        pause_btn = 1'b0;
        chk("unpause_state", state_o, S_PLAY);
        chk("unpause_run", ball_run, 1);
`else
        chk("nopause_state", state_o, S_PLAY);
        chk("nopause_run", ball_run, 1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
